mantissa_addsub_pipe: RTL and testbench

//  Pipelined sign-magnitude mantissa adder/subtractor with valid/ready flow control.

---
 rtl/mantissa_addsub_pipe.sv | 155 +++++++++++++++
 tb/tb_mantissa_addsub_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_addsub_pipe.sv
// Pipelined sign-magnitude mantissa adder/subtractor with valid/ready flow control.
// Define MANTISSA_ADDSUB_LZC_EN to add the leading-zero-count output (lzc).
module mantissa_addsub_pipe #(
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned PIPE_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANTISSA_WIDTH+3:0] man_a,
  input  logic [MANTISSA_WIDTH+3:0] man_b,
  input  logic                      ma_sign,
  input  logic                      mb_sign,
  input  logic                      operation_select,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANTISSA_WIDTH+3:0] result,
  output logic                      carry_out,
  output logic                      res_sign,
  output logic                      res_zero
`ifdef MANTISSA_ADDSUB_LZC_EN
  ,
  output logic [$clog2(MANTISSA_WIDTH+5)-1:0] lzc
`endif
);

  localparam int unsigned W    = MANTISSA_WIDTH + 4;
  localparam int unsigned PW   = W + 3;
  localparam int unsigned Last = PIPE_STAGES - 1;

  // Stage-1 arithmetic
  logic         eff_sub;
  logic         a_ge_b;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic [W-1:0] res_c;
  logic         carry_c;
  logic         sign_c;
  logic         zero_c;

  always_comb begin
    eff_sub = operation_select ^ ma_sign ^ mb_sign;
    a_ge_b  = (man_a >= man_b);
    sum     = {1'b0, man_a} + {1'b0, man_b};
    diff    = a_ge_b ? (man_a - man_b) : (man_b - man_a);
    if (!eff_sub) begin
      res_c   = sum[W-1:0];
      carry_c = sum[W];
      sign_c  = ma_sign;
    end else begin
      res_c   = diff;
      carry_c = 1'b0;
      // Exact cancellation always yields +0
      if (diff == '0) begin
        sign_c = 1'b0;
      end else if (a_ge_b) begin
        sign_c = ma_sign;
      end else begin
        sign_c = mb_sign ^ operation_select;
      end
    end
    zero_c = (res_c == '0);
  end

  // Slot payload: {carry, sign, zero, result}
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_d;
  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES-1:0] in_v;
  logic [PW-1:0]          data_q [PIPE_STAGES];
  logic [PW-1:0]          data_d [PIPE_STAGES];
  logic [PW-1:0]          in_d   [PIPE_STAGES];

  // A slot may load when it is empty or its successor is taking its content this cycle
  always_comb begin : adv_chain
    logic rdy;
    rdy = out_ready;
    for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) begin
      rdy    = !valid_q[i] || rdy;
      adv[i] = rdy;
    end
  end

  always_comb begin
    in_v[0] = in_valid;
    in_d[0] = {carry_c, sign_c, zero_c, res_c};
    for (int i = 1; i < int'(PIPE_STAGES); i++) begin
      in_v[i] = valid_q[i-1];
      in_d[i] = data_q[i-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < int'(PIPE_STAGES); i++) begin
      if (adv[i]) begin
        valid_d[i] = in_v[i];
        if (in_v[i]) begin
          data_d[i] = in_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(PIPE_STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[Last];
  assign {carry_out, res_sign, res_zero, result} = data_q[Last];

`ifdef MANTISSA_ADDSUB_LZC_EN
  localparam int unsigned LW = $clog2(W + 1);

  function automatic logic [LW-1:0] count_lz(input logic [W-1:0] v);
    count_lz = LW'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (v[i]) count_lz = LW'(int'(W) - 1 - i);
    end
  endfunction

  logic [LW-1:0] lzc_q;
  logic [LW-1:0] lzc_d;

  // Counted as data enters the last slot so it travels with the result
  always_comb begin
    lzc_d = lzc_q;
    if (adv[Last] && in_v[Last]) begin
      lzc_d = count_lz(in_d[Last][W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lzc_q <= '0;
    end else begin
      lzc_q <= lzc_d;
    end
  end

  assign lzc = lzc_q;
`endif

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// Self-checking bench for mantissa_addsub_pipe: directed cases plus randomized streams
// checked against a signed-arithmetic reference model.
module tb_mantissa_addsub_pipe;

  localparam int MW = 23;
  localparam int W  = MW + 4;
  localparam int PS = 2;

  logic         clk;
  logic         arst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] man_a;
  logic [W-1:0] man_b;
  logic         ma_sign;
  logic         mb_sign;
  logic         operation_select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         res_sign;
  logic         res_zero;
`ifdef MANTISSA_ADDSUB_LZC_EN
  logic [$clog2(W+1)-1:0] lzc;
`endif

  mantissa_addsub_pipe #(
    .MANTISSA_WIDTH(MW),
    .PIPE_STAGES   (PS)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .man_a           (man_a),
    .man_b           (man_b),
    .ma_sign         (ma_sign),
    .mb_sign         (mb_sign),
    .operation_select(operation_select),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result),
    .carry_out       (carry_out),
    .res_sign        (res_sign),
    .res_zero        (res_zero)
`ifdef MANTISSA_ADDSUB_LZC_EN
    ,
    .lzc             (lzc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         sign;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Reference: treat operands as signed integers and take |A op B|
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sa, input logic sb, input logic op);
    longint va, vb, r, mag;
    exp_t   e;
    va = sa ? -longint'(a) : longint'(a);
    vb = sb ? -longint'(b) : longint'(b);
    r  = op ? (va - vb) : (va + vb);
    mag = (r < 0) ? -r : r;
    e.res   = mag[W-1:0];
    e.carry = mag[W];
    e.zero  = (mag[W-1:0] == '0);
    if (r < 0)      e.sign = 1'b1;
    else if (r > 0) e.sign = 1'b0;
    else            e.sign = (sa ^ sb ^ op) ? 1'b0 : sa;
    return e;
  endfunction

  function automatic int lz_of(input logic [W-1:0] v);
    int n;
    logic [W-1:0] t;
    n = W;
    t = v;
    while (t != '0) begin
      t = t >> 1;
      n--;
    end
    return n;
  endfunction

  function automatic logic [63:0] dut_out();
    return 64'({result, carry_out, res_sign, res_zero});
  endfunction

  // Compare process: pops the model queue on every output transfer
  always @(negedge clk) begin
    exp_t e;
    if (!arst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && !out_ready && exp_q.size() > 0) begin
        e = exp_q[0];
        check("stalled_output", dut_out(), 64'({e.res, e.carry, e.sign, e.zero}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_without_input", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("result_vs_model", dut_out(), 64'({e.res, e.carry, e.sign, e.zero}));
`ifdef MANTISSA_ADDSUB_LZC_EN
          check("lzc_vs_model", 64'(lzc), 64'(lz_of(e.res)));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(man_a, man_b, ma_sign, mb_sign, operation_select));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, input logic op);
    in_valid = 1'b1;
    man_a = a;
    man_b = b;
    ma_sign = sa;
    mb_sign = sb;
    operation_select = op;
  endtask

  task automatic rand_drive();
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    case ($urandom_range(0, 7))
      0: b = a;
      1: begin a = '0; b = '0; end
      2: a = W'($urandom_range(0, 15));
      default: ;
    endcase
    drive(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  // One isolated transaction with out_ready=1; checks latency and the literal result
  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sa, input logic sb, input logic op,
                         input logic [W-1:0] r, input logic c, input logic s, input logic z);
    int lat;
    @(posedge clk); #1;
    drive(a, b, sa, sb, op);
    @(negedge clk);
    check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(PS));
    check({nm, "_result"}, dut_out(), 64'({r, c, s, z}));
  endtask

  initial begin
    int zeros, sent, cyc, waited;
    logic acc;
    arst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_outputs", dut_out(), 64'(0));
    repeat (2) @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'(1));

    // Directed cases
    run_one("t1_overflow", 27'h400_0000, 27'h400_0000, 0, 0, 0, '0, 1, 0, 1);
    run_one("t2_sub_pos", 5, 3, 0, 0, 1, 2, 0, 0, 0);
    run_one("t2_sub_neg", 3, 5, 0, 0, 1, 2, 0, 1, 0);
    run_one("t3_cancel", 10, 10, 0, 1, 0, 0, 0, 0, 1);
    run_one("t3_neg_add", 7, 2, 1, 0, 1, 9, 0, 1, 0);
    run_one("neg_zero_add", 0, 0, 1, 0, 1, 0, 0, 1, 1);
`ifdef MANTISSA_ADDSUB_LZC_EN
    run_one("lzc_one", 1, 0, 0, 0, 0, 1, 0, 0, 0);
    check("lzc_one_val", 64'(lzc), 64'(26));
    run_one("lzc_zero", 8, 8, 0, 0, 1, 0, 0, 0, 1);
    check("lzc_zero_val", 64'(lzc), 64'(27));
`endif

    // Backpressure: two buffered, third held until the first leaves
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(5, 3, 0, 0, 1);
    @(posedge clk); #1;
    drive(100, 20, 0, 0, 0);
    @(posedge clk); #1;
    drive(50, 70, 0, 0, 1);
    @(negedge clk);
    check("stall_in_ready_low", 64'(in_ready), 64'(0));
    check("stall_buffered", 64'(exp_q.size()), 64'(2));
    repeat (3) @(posedge clk);
    #1;
    check("stall_still_blocked", 64'(in_ready), 64'(0));
    check("stall_head", dut_out(), 64'({27'd2, 1'b0, 1'b0, 1'b0}));
    out_ready = 1'b1;
    #1;
    check("release_in_ready_comb", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second_at_head", dut_out(), 64'({27'd120, 1'b0, 1'b0, 1'b0}));
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("stall_drained", 64'(exp_q.size()), 64'(0));

    // Back-to-back random stream
    zeros = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      rand_drive();
      @(negedge clk);
      if (!in_ready) zeros++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stream_in_ready_never_low", 64'(zeros), 64'(0));

    // Random valid and out_ready toggling
    sent = 0;
    cyc = 0;
    acc = 1'b0;
    while (sent < 200 && cyc < 5000) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        if ($urandom_range(0, 3) != 0) rand_drive();
        else in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("random_sent", 64'(sent), 64'(200));
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("random_drained", 64'(exp_q.size()), 64'(0));

    // Reset with two transactions in flight
    out_ready = 1'b0;
    drive(11, 4, 0, 0, 0);
    @(posedge clk); #1;
    drive(9, 1, 0, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_outputs", dut_out(), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    #2 arst_n = 1'b1;
    out_ready = 1'b1;
    zeros = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) zeros++;
    end
    check("no_stale_after_reset", 64'(zeros), 64'(0));
    run_one("post_reset", 3, 5, 1, 1, 0, 8, 0, 1, 0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
